// File: rtl/uart_rx_fifo_if.sv
// Purpose: groups the UART receive-side strobes and the FIFO head/consumer handshake.
// Latency: none; this only bundles wires.
// Backpressure: out_ready from the consumer; the receive side has none and may overrun.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       frame_error;
  logic [7:0] out_data;
  logic       out_perr;
  logic       out_ferr;
  logic       out_valid;
  logic       out_ready;

  // The producer/consumer side: drives received frames and accepts head entries.
  modport master (
    output rx_data, rx_valid, parity_error, frame_error, out_ready,
    input  out_data, out_perr, out_ferr, out_valid
  );

  // The FIFO side.
  modport slave (
    input  rx_data, rx_valid, parity_error, frame_error, out_ready,
    output out_data, out_perr, out_ferr, out_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: first-word-fall-through FIFO for UART frames, storing byte plus parity/frame flags.
// Latency: a push into an empty FIFO shows as out_valid one cycle later.
// Backpressure: out_ready stalls the head; a push into a full FIFO without a pop is dropped and sets overrun.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_rx_fifo_if.slave            bus,
  input  logic                     clr_overrun,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overrun,
  output logic [7:0]               perr_cnt,
  output logic [7:0]               ferr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  entry_t          head;
  entry_t          wr_entry;
  logic            push_req;
  logic            pop;
  logic            push_ok;
  logic            drop;

  assign head = mem[rd_ptr];

  // Decide this cycle's push/pop; a full FIFO still accepts when the head leaves in the same cycle.
  always_comb begin
    push_req      = bus.rx_valid | bus.frame_error;
    pop           = bus.out_valid & bus.out_ready;
    push_ok       = push_req & ((count < CW'(DEPTH)) | pop);
    drop          = push_req & ~push_ok;
    wr_entry.perr = bus.parity_error;
    wr_entry.ferr = bus.frame_error;
    wr_entry.data = bus.rx_data;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are never reset, the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= wr_entry;
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  // Saturating error statistics, counting only frames that were actually stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_cnt <= '0;
      ferr_cnt <= '0;
    end else begin
      if (push_ok && bus.parity_error && perr_cnt != 8'hFF) perr_cnt <= perr_cnt + 8'd1;
      if (push_ok && bus.frame_error  && ferr_cnt != 8'hFF) ferr_cnt <= ferr_cnt + 8'd1;
    end
  end

  // Status derived from the registered count so all flags agree in every cycle.
  always_comb begin
    empty         = (count == '0);
    full          = (count == CW'(DEPTH));
    almost_full   = (count >= CW'(AF_THRESH));
    bus.out_valid = ~empty;
    bus.out_data  = bus.out_valid ? head.data : 8'h00;
    bus.out_perr  = bus.out_valid & head.perr;
    bus.out_ferr  = bus.out_valid & head.ferr;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed self-checking bench for uart_rx_fifo with a queue scoreboard and occupancy model.
// Latency: checks head contents before each popping edge and status one step after every edge.
// Backpressure: out_ready is driven per step to exercise stall, drain and full-with-pop cases.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk;
  logic       rst;
  logic       clr_overrun;
  logic [4:0] count;
  logic       empty, full, almost_full, overrun;
  logic [7:0] perr_cnt, ferr_cnt;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .clr_overrun (clr_overrun),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overrun     (overrun),
    .perr_cnt    (perr_cnt),
    .ferr_cnt    (ferr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb [$];
  int         m_perr;
  int         m_ferr;
  logic       m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    int n;
    n = sb.size();
    chk("count",       32'(count),       32'(n));
    chk("empty",       32'(empty),       32'(n == 0));
    chk("full",        32'(full),        32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("out_valid",   32'(bus.out_valid), 32'(n != 0));
    chk("overrun",     32'(overrun),     32'(m_ovr));
    chk("perr_cnt",    32'(perr_cnt),    32'(m_perr));
    chk("ferr_cnt",    32'(ferr_cnt),    32'(m_ferr));
  endtask

  // One clock step: drive inputs, check the head if it is consumed, update the model, advance, check status.
  task automatic step(input logic rv, input logic fe, input logic pe,
                      input logic [7:0] d, input logic rdy, input logic clr);
    logic [9:0] e;
    logic       push, pop, acc;
    int         n;
    bus.rx_valid     = rv;
    bus.frame_error  = fe;
    bus.parity_error = pe;
    bus.rx_data      = d;
    bus.out_ready    = rdy;
    clr_overrun      = clr;
    #1;
    n    = sb.size();
    push = rv | fe;
    pop  = rdy && (n > 0);
    if (pop) begin
      e = sb.pop_front();
      chk("head_data", 32'(bus.out_data), 32'(e[7:0]));
      chk("head_perr", 32'(bus.out_perr), 32'(e[9]));
      chk("head_ferr", 32'(bus.out_ferr), 32'(e[8]));
    end
    acc = push && ((n < DEPTH) || pop);
    if (acc) begin
      sb.push_back({pe, fe, d});
      if (pe && m_perr < 255) m_perr++;
      if (fe && m_ferr < 255) m_ferr++;
    end
    if (push && !acc) m_ovr = 1'b1;
    else if (clr)     m_ovr = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_valid    = 1'b0;
    bus.frame_error = 1'b0;
    clr_overrun     = 1'b0;
    chk_status();
  endtask

  task automatic drain();
    while (sb.size() > 0) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Reset asserted together with a push, a pop and a clear to show reset wins.
  task automatic do_reset();
    rst              = 1'b1;
    bus.rx_valid     = 1'b1;
    bus.rx_data      = 8'hEE;
    bus.parity_error = 1'b1;
    bus.frame_error  = 1'b0;
    bus.out_ready    = 1'b1;
    clr_overrun      = 1'b1;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.parity_error = 1'b0;
    bus.out_ready    = 1'b0;
    clr_overrun      = 1'b0;
    sb.delete();
    m_perr = 0;
    m_ferr = 0;
    m_ovr  = 1'b0;
    chk("rst_count",    32'(count),        32'd0);
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_af",       32'(almost_full),  32'd0);
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_overrun",  32'(overrun),      32'd0);
    chk("rst_perr_cnt", 32'(perr_cnt),     32'd0);
    chk("rst_ferr_cnt", 32'(ferr_cnt),     32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_perr", 32'(bus.out_perr), 32'd0);
    chk("rst_out_ferr", 32'(bus.out_ferr), 32'd0);
  endtask

  initial begin
    logic seen;
    rst              = 1'b1;
    clr_overrun      = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.frame_error  = 1'b0;
    bus.parity_error = 1'b0;
    bus.rx_data      = 8'h00;
    bus.out_ready    = 1'b0;
    m_perr = 0;
    m_ferr = 0;
    m_ovr  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single push with consumer stalled: head visible one cycle later.
    step(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
    chk("a5_valid", 32'(bus.out_valid), 32'd1);
    chk("a5_data",  32'(bus.out_data),  32'hA5);
    chk("a5_count", 32'(count),         32'd1);
    chk("a5_empty", 32'(empty),         32'd0);
    drain();

    // Fill, then one more push that must be dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    chk("ovf_full",    32'(full),    32'd1);
    chk("ovf_count",   32'(count),   32'd16);
    chk("ovf_overrun", 32'(overrun), 32'd1);
    seen = 1'b0;
    while (sb.size() > 0) begin
      #1;
      if (bus.out_data == 8'h3C) seen = 1'b1;
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("ovf_no_3c", 32'(seen), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Full FIFO with simultaneous push and pop: accepted, no overrun.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
    chk("fp_count",   32'(count),   32'd16);
    chk("fp_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (i == DEPTH - 1) chk("fp_new_is_16th", 32'(bus.out_data), 32'h77);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Error flags travel with their entries.
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("err_head_perr", 32'(bus.out_perr), 32'd1);
    chk("err_head_ferr", 32'(bus.out_ferr), 32'd0);
    chk("err_head_data", 32'(bus.out_data), 32'h55);
    chk("err_perr_cnt",  32'(perr_cnt),     32'd1);
    chk("err_ferr_cnt",  32'(ferr_cnt),     32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("err_2nd_ferr", 32'(bus.out_ferr), 32'd1);
    chk("err_2nd_data", 32'(bus.out_data), 32'h00);
    drain();
    step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    chk("both_count", 32'(count),        32'd1);
    chk("both_ferr",  32'(bus.out_ferr), 32'd1);
    drain();

    // Parity counter saturation under continuous draining.
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
    chk("perr_sat", 32'(perr_cnt), 32'd255);
    drain();

    // Reset with entries stored; the next push becomes the head.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
    chk("post_rst_head",  32'(bus.out_data), 32'h99);
    chk("post_rst_count", 32'(count),        32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries; it is a power of two and at least 2.
REQ-002 The block SHALL have parameter AF_THRESH, default 12, meaning the occupancy at or above which almost_full asserts.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all logic samples on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  byte from the UART receiver.
REQ-007 rx_valid  input  1  single-cycle pulse: good stop bit, byte complete.
REQ-008 parity_error  input  1  parity flag for the current frame; sampled together with rx_valid or frame_error.
REQ-009 frame_error  input  1  single-cycle pulse: bad stop bit, frame complete.
REQ-010 out_data  output  8  byte at the FIFO head.
REQ-011 out_perr  output  1  parity flag stored with the head entry.
REQ-012 out_ferr  output  1  frame flag stored with the head entry.
REQ-013 out_valid  output  1  head entry is valid.
REQ-014 out_ready  input  1  consumer accepts the head entry.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 empty, full, almost_full  output  1 each  occupancy status.
REQ-017 overrun  output  1  sticky flag: a frame was dropped.
REQ-018 clr_overrun  input  1  clears overrun.
REQ-019 perr_cnt, ferr_cnt  output  8 each  saturating counts of frames that were pushed with each error flag.

Function
REQ-020 A push request SHALL occur on any cycle where rx_valid=1 or frame_error=1; the entry is {parity_error, frame_error, rx_data}.
REQ-021 A frame with frame_error=1 SHALL be pushed with its byte and out_ferr=1; it SHALL NOT be discarded.
REQ-022 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-023 The FIFO SHALL be first-word-fall-through: out_data/out_perr/out_ferr show the head entry whenever out_valid=1, and are don't-care otherwise.
REQ-024 Write-to-out_valid latency SHALL be 1 cycle: a push into an empty FIFO at edge N gives out_valid=1 after edge N.
REQ-025 A push SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-026 A push with count==DEPTH and no pop SHALL be dropped: FIFO contents and count are unchanged, and overrun is set to 1.
REQ-027 A simultaneous accepted push and pop SHALL leave count unchanged; pointers advance modulo DEPTH and wrap silently.
REQ-028 A pop when empty is impossible, because out_valid=0.
REQ-029 Status flags: count = number of stored entries; empty = (count==0); full = (count==DEPTH); almost_full = (count>=AF_THRESH); out_valid = !empty. All are registered-consistent with count in the same cycle.
REQ-030 overrun SHALL clear on clr_overrun=1; if an overrun event occurs in the same cycle, set wins.
REQ-031 perr_cnt SHALL increment by 1 per accepted push with parity_error=1, saturating at 255.
REQ-032 ferr_cnt SHALL increment by 1 per accepted push with frame_error=1, saturating at 255.
REQ-033 Dropped frames SHALL NOT update perr_cnt or ferr_cnt.
REQ-034 rx_valid=1 and frame_error=1 in the same cycle SHALL produce one push with ferr=1.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL set: read and write pointers=0, count=0, empty=1, full=0, almost_full=0, out_valid=0, overrun=0, perr_cnt=0, ferr_cnt=0.
REQ-036 out_data, out_perr and out_ferr SHALL be 0 after reset.
REQ-037 Reset SHALL take priority over push, pop and clr_overrun in the same cycle.
REQ-038 Reset mid-operation SHALL discard all stored entries; the next push after rst deasserts lands in entry 0.

Verification
REQ-039 Bench scenario: push 0xA5 with out_ready=0 -> out_valid=1 and out_data=0xA5 one cycle later; count=1; empty=0.
REQ-040 Bench scenario: 16 pushes with no pops, then a 17th push of 0x3C -> full=1, count=16, overrun=1; after draining, 0x3C never appears.
REQ-041 Bench scenario: full FIFO, push and pop in the same cycle -> count stays 16, overrun=0; the new byte is read 16th.
REQ-042 Bench scenario: push 0x55 with parity_error=1, then frame_error pulse with byte 0x00 -> head shows out_perr=1; second entry shows out_ferr=1; perr_cnt=1, ferr_cnt=1.
REQ-043 Bench scenario: 300 pushes with parity_error=1 under continuous draining -> perr_cnt=255 saturated.
REQ-044 Bench scenario: rst pulse with 5 entries stored -> count=0, empty=1, overrun=0, counters=0; the next push is read back first.
